// File: rtl/req_encoder_pkg.sv
// Shared definitions for the 32-to-5 request encoder: FSM encoding and default sizes.
package req_encoder_pkg;

    localparam int unsigned N_REQ_DEF = 32;
    localparam int unsigned IDX_W_DEF = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/pri_encoder_32x5.sv
// Combinational wrap-around priority encoder: finds the first set bit of vec_i
// scanning upward from offset_i, modulo N_REQ.
module pri_encoder_32x5 #(
    parameter int unsigned N_REQ = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic [N_REQ-1:0] vec_i,
    input  logic [IDX_W-1:0] offset_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] k;

    // Scan offset, offset+1, ... and keep the first hit.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            k = IDX_W'((32'(offset_i) + i) % N_REQ);
            if (!any_o && vec_i[k]) begin
                idx_o = k;
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/req_encoder_32x5.sv
// Sequential 32-to-5 request encoder. Requests are latched into a sticky
// pending register; the winner's index is offered with a VALID/ACK handshake
// and its pending bit is cleared on acknowledge.
// Build option: define REQ_ENCODER_RR_EN for round-robin priority; otherwise
// the lowest set index wins.
module req_encoder_32x5
    import req_encoder_pkg::*;
#(
    parameter int unsigned N_REQ = N_REQ_DEF,
    parameter int unsigned IDX_W = IDX_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_REQ-1:0] REQ,
    input  logic             ACK,
    output logic [IDX_W-1:0] IDX,
    output logic             VALID,
    output logic [N_REQ-1:0] PENDING
);

    state_e           state_q, state_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;

    logic             handshake;
    logic [N_REQ-1:0] clr;
    logic [IDX_W-1:0] offset;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    // Handshake clears the granted bit; a same-cycle REQ on that bit re-sets it.
    always_comb begin
        handshake = valid_q & ACK;
        clr       = handshake ? (N_REQ'(1) << idx_q) : '0;
        pending_d = (pending_q & ~clr) | REQ;
    end

`ifdef REQ_ENCODER_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_inc;

    // Selection at a handshake already scans from the advanced pointer.
    always_comb begin
        idx_inc = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
        ptr_d   = handshake ? idx_inc : ptr_q;
        offset  = ptr_d;
    end

    // Round-robin pointer register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    assign offset = '0;
`endif

    pri_encoder_32x5 #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pri_encoder (
        .vec_i    (pending_d),
        .offset_i (offset),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (win_any) state_d = GRANT;
            GRANT: if (handshake && !win_any) state_d = IDLE;
        endcase
    end

    // Output next values: IDX/VALID load on entry to GRANT or on a handshake.
    always_comb begin
        idx_d   = idx_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    idx_d   = win_idx;
                    valid_d = 1'b1;
                end
            end
            GRANT: begin
                if (handshake) begin
                    if (win_any) idx_d = win_idx;
                    valid_d = win_any;
                end
            end
        endcase
    end

    assign IDX     = idx_q;
    assign VALID   = valid_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_req_encoder_32x5.sv
// Self-checking bench for req_encoder_32x5. Define REQ_ENCODER_RR_EN for the
// round-robin build.
module tb_req_encoder_32x5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] REQ = '0;
    logic        ACK = 1'b0;
    logic [4:0]  IDX;
    logic        VALID;
    logic [31:0] PENDING;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        chk_idx;
        logic        valid;
        logic [4:0]  idx;
        logic [31:0] pend;
    } exp_t;

    exp_t exp_q[$];

    req_encoder_32x5 dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .REQ     (REQ),
        .ACK     (ACK),
        .IDX     (IDX),
        .VALID   (VALID),
        .PENDING (PENDING)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        REQ   = '0;
        ACK   = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        RESET = 1'b1;
        REQ   = 32'hFFFF_FFFF;
        ACK   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin
                RESET = 1'b0;
                REQ   = '0;
                ACK   = 1'b0;
            end
            e = '{1'b1, 1'b0, 5'd0, 32'h0};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 3;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL reset c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL reset c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (IDX !== e.idx) begin
                n_fail++; $display("FAIL reset c%0d IDX got %0d want %0d", c, IDX, e.idx);
            end
        end
    endtask

    task automatic test_single();
        logic [31:0] rq [3] = '{32'h100, 32'h0, 32'h0};
        logic        ak [3] = '{1'b0, 1'b1, 1'b0};
        logic        ev [3] = '{1'b1, 1'b0, 1'b0};
        logic [4:0]  ei [3] = '{5'd8, 5'd0, 5'd0};
        logic [31:0] ep [3] = '{32'h100, 32'h0, 32'h0};
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            REQ = rq[c];
            ACK = ak[c];
            e = '{ev[c], ev[c], ei[c], ep[c]};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL single c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL single c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL single c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rq [5] = '{32'h8000_0011, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        ak [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        ev [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [4:0]  ei [5] = '{5'd0, 5'd4, 5'd31, 5'd0, 5'd0};
        logic [31:0] ep [5] = '{32'h8000_0011, 32'h8000_0010, 32'h8000_0000, 32'h0, 32'h0};
        exp_t e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            REQ = rq[c];
            ACK = ak[c];
            e = '{ev[c], ev[c], ei[c], ep[c]};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL b2b c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL b2b c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL b2b c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
    endtask

    task automatic test_frozen();
        logic [31:0] rq [5] = '{32'h20, 32'h2, 32'h0, 32'h0, 32'h0};
        logic        ak [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        ev [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0]  ei [5] = '{5'd5, 5'd5, 5'd5, 5'd1, 5'd0};
        logic [31:0] ep [5] = '{32'h20, 32'h22, 32'h22, 32'h2, 32'h0};
        exp_t e;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            REQ = rq[c];
            ACK = ak[c];
            e = '{ev[c], ev[c], ei[c], ep[c]};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL frozen c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL frozen c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL frozen c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] rq [3] = '{32'h8, 32'h8, 32'h0};
        logic        ak [3] = '{1'b0, 1'b1, 1'b1};
        logic        ev [3] = '{1'b1, 1'b1, 1'b0};
        logic [4:0]  ei [3] = '{5'd3, 5'd3, 5'd0};
        logic [31:0] ep [3] = '{32'h8, 32'h8, 32'h0};
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            REQ = rq[c];
            ACK = ak[c];
            e = '{ev[c], ev[c], ei[c], ep[c]};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL setclr c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL setclr c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL setclr c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
    endtask

    // REQ 0 and 2 held with ACK every cycle (the first ACK arrives while idle).
    task automatic test_alternate();
        logic [31:0] rq [7] = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h0, 32'h0};
        logic        ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef REQ_ENCODER_RR_EN
        logic [4:0]  ei [7] = '{5'd0, 5'd2, 5'd0, 5'd2, 5'd0, 5'd2, 5'd0};
`else
        logic [4:0]  ei [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0};
`endif
        logic [31:0] ep [7] = '{32'h5, 32'h5, 32'h5, 32'h5, 32'h5, 32'h4, 32'h0};
        exp_t e;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            REQ = rq[c];
            ACK = 1'b1;
            e = '{ev[c], ev[c], ei[c], ep[c]};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL alt c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL alt c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL alt c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
        ACK = 1'b0;
    endtask

    // All 32 requests at once, then ACK held: one grant per cycle in index order.
    task automatic test_all_pending();
        exp_t e;
        do_reset();
        for (int c = 0; c < 34; c++) begin
            REQ = (c == 0) ? 32'hFFFF_FFFF : 32'h0;
            ACK = (c != 0);
            if (c < 32) e = '{1'b1, 1'b1, 5'(c), 32'hFFFF_FFFF << c};
            else        e = '{1'b0, 1'b0, 5'd0, 32'h0};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL allpend c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL allpend c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL allpend c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
        ACK = 1'b0;
    endtask

    // Reset asserted while a grant is outstanding, with REQ and ACK active.
    task automatic test_reset_mid_grant();
        logic [31:0] rq [3] = '{32'h30, 32'h1, 32'h0};
        logic        rs [3] = '{1'b0, 1'b1, 1'b0};
        logic        ak [3] = '{1'b0, 1'b1, 1'b0};
        logic        ev [3] = '{1'b1, 1'b0, 1'b0};
        logic [4:0]  ei [3] = '{5'd4, 5'd0, 5'd0};
        logic [31:0] ep [3] = '{32'h30, 32'h0, 32'h0};
        exp_t e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            REQ   = rq[c];
            ACK   = ak[c];
            RESET = rs[c];
            e = '{1'b1, ev[c], ei[c], ep[c]};
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            n_checks += 2;
            if (VALID !== e.valid) begin
                n_fail++; $display("FAIL rstmid c%0d VALID got %0b want %0b", c, VALID, e.valid);
            end
            if (PENDING !== e.pend) begin
                n_fail++; $display("FAIL rstmid c%0d PENDING got %h want %h", c, PENDING, e.pend);
            end
            if (e.chk_idx) begin
                n_checks++;
                if (IDX !== e.idx) begin
                    n_fail++; $display("FAIL rstmid c%0d IDX got %0d want %0d", c, IDX, e.idx);
                end
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_frozen();
        test_same_cycle();
        test_alternate();
        test_all_pending();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
